// File: rtl/seq_shifter_if.sv
// Request/response bundle for seq_shifter: valid/ready request and result channels.
// carry_out exists only when SEQ_SHIFTER_CARRY_EN is defined.
interface seq_shifter_if #(
   parameter int WIDTH = 16,
   parameter int AMT_W = $clog2(WIDTH)
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] shift_in;
   logic [2:0]       shift_op;
   logic [AMT_W-1:0] shift_amt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] shift_out;
`ifdef SEQ_SHIFTER_CARRY_EN
   logic             carry_out;
`endif

   modport master (
      output in_valid, shift_in, shift_op, shift_amt, out_ready,
`ifdef SEQ_SHIFTER_CARRY_EN
      input  carry_out,
`endif
      input  in_ready, out_valid, shift_out
   );

   modport slave (
      input  in_valid, shift_in, shift_op, shift_amt, out_ready,
`ifdef SEQ_SHIFTER_CARRY_EN
      output carry_out,
`endif
      output in_ready, out_valid, shift_out
   );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: LSL/LSR/ASR/ROL/ROR by 0..WIDTH-1, one bit per clock, valid/ready both sides.
// Optional carry_out of the last bit shifted out is enabled by defining SEQ_SHIFTER_CARRY_EN.
module seq_shifter #(
   parameter int WIDTH = 16,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input logic          clk,
   input logic          reset,
   seq_shifter_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
   typedef enum logic [2:0] {
      OP_PASS = 3'd0, OP_LSL = 3'd1, OP_LSR = 3'd2,
      OP_ASR  = 3'd3, OP_ROL = 3'd4, OP_ROR = 3'd5
   } op_e;

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] step_val;
   logic             accept_shift;
`ifdef SEQ_SHIFTER_CARRY_EN
   logic             carry_q, carry_d;
   logic             step_bit;
`endif

   assign accept_shift = (bus.shift_op inside {[3'd1:3'd5]}) && (bus.shift_amt != '0);

   // One-bit step of the working register for the latched op.
   always_comb begin
      step_val = work_q;
`ifdef SEQ_SHIFTER_CARRY_EN
      step_bit = carry_q;
`endif
      case (op_q)
         OP_LSL: step_val = {work_q[WIDTH-2:0], 1'b0};
         OP_LSR: step_val = {1'b0, work_q[WIDTH-1:1]};
         OP_ASR: step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
         OP_ROL: step_val = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
         OP_ROR: step_val = {work_q[0], work_q[WIDTH-1:1]};
         default: step_val = work_q;
      endcase
`ifdef SEQ_SHIFTER_CARRY_EN
      case (op_q)
         OP_LSL, OP_ROL:         step_bit = work_q[WIDTH-1];
         OP_LSR, OP_ASR, OP_ROR: step_bit = work_q[0];
         default:                step_bit = carry_q;
      endcase
`endif
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d = state_q;
      op_d    = op_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
`ifdef SEQ_SHIFTER_CARRY_EN
      carry_d = carry_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               work_d  = bus.shift_in;
               state_d = ST_SHIFT;
`ifdef SEQ_SHIFTER_CARRY_EN
               carry_d = 1'b0;
`endif
               // Non-shifting requests take one identity step so latency is always max(amt,1).
               if (accept_shift) begin
                  op_d  = op_e'(bus.shift_op);
                  cnt_d = bus.shift_amt;
               end else begin
                  op_d  = OP_PASS;
                  cnt_d = AMT_W'(1);
               end
            end
         end
         ST_SHIFT: begin
            work_d = step_val;
            cnt_d  = cnt_q - 1'b1;
`ifdef SEQ_SHIFTER_CARRY_EN
            carry_d = step_bit;
`endif
            if (cnt_q == AMT_W'(1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= OP_PASS;
         work_q  <= '0;
         cnt_q   <= '0;
`ifdef SEQ_SHIFTER_CARRY_EN
         carry_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
`ifdef SEQ_SHIFTER_CARRY_EN
         carry_q <= carry_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.shift_out = work_q;
`ifdef SEQ_SHIFTER_CARRY_EN
   assign bus.carry_out = carry_q;
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (WIDTH=16): arithmetic reference model, per-cycle compare,
// directed boundary cases and randomized requests with backpressure.
module tb_seq_shifter;
   localparam int WIDTH = 16;
   localparam int AMT_W = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   seq_shifter_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

   seq_shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_shift(input logic [2:0] op, input logic [3:0] amt);
      return (op >= 3'd1) && (op <= 3'd5) && (amt != 4'd0);
   endfunction

   function automatic logic [15:0] ref_shift(input logic [15:0] x, input logic [2:0] op,
                                             input logic [3:0] amt);
      int a;
      a = int'(amt);
      if (!is_shift(op, amt)) return x;
      case (op)
         3'd1: return x << a;
         3'd2: return x >> a;
         3'd3: return 16'($signed(x) >>> a);
         3'd4: return (x << a) | (x >> (16 - a));
         default: return (x >> a) | (x << (16 - a));
      endcase
   endfunction

   function automatic logic ref_carry(input logic [15:0] x, input logic [2:0] op,
                                      input logic [3:0] amt);
      int a;
      a = int'(amt);
      if (!is_shift(op, amt)) return 1'b0;
      if (op == 3'd1 || op == 3'd4) return x[16 - a];
      return x[a - 1];
   endfunction

   // Reference model: idle / busy(n cycles left) / done, updated at each rising edge.
   int          m_phase = 0;
   int          m_left  = 0;
   logic [15:0] m_res   = '0;
   logic        m_carry = 1'b0;

   initial begin : compare_proc
      forever begin
         @(posedge clk or posedge reset);
         if (reset) m_phase = 0;
         else begin
            case (m_phase)
               0: if (bus.in_valid) begin
                     m_res   = ref_shift(bus.shift_in, bus.shift_op, bus.shift_amt);
                     m_carry = ref_carry(bus.shift_in, bus.shift_op, bus.shift_amt);
                     m_left  = is_shift(bus.shift_op, bus.shift_amt) ? int'(bus.shift_amt) : 1;
                     m_phase = 1;
                  end
               1: begin
                     m_left--;
                     if (m_left == 0) m_phase = 2;
                  end
               default: if (bus.out_ready) m_phase = 0;
            endcase
         end
         @(negedge clk);
         if (reset) begin
            m_phase = 0;
            check("rst_in_ready", 32'(bus.in_ready), 32'd1);
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_shift_out", 32'(bus.shift_out), 32'd0);
`ifdef SEQ_SHIFTER_CARRY_EN
            check("rst_carry_out", 32'(bus.carry_out), 32'd0);
`endif
         end else begin
            check("in_ready", 32'(bus.in_ready), 32'(m_phase == 0));
            check("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
            if (m_phase == 2) begin
               check("shift_out", 32'(bus.shift_out), 32'(m_res));
`ifdef SEQ_SHIFTER_CARRY_EN
               check("carry_out", 32'(bus.carry_out), 32'(m_carry));
`endif
            end
         end
      end
   end

   task automatic junk_inputs();
      bus.shift_in  = 16'($urandom);
      bus.shift_op  = 3'($urandom_range(0, 7));
      bus.shift_amt = 4'($urandom_range(0, 15));
   endtask

   task automatic send(input logic [15:0] x, input logic [2:0] op, input logic [3:0] amt,
                       input int stall, output logic [15:0] res);
      int n;
      n = 0;
      while (!bus.in_ready && n < 64) begin @(posedge clk); #1; n++; end
      if (!bus.in_ready) check("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.shift_in  = x;
      bus.shift_op  = op;
      bus.shift_amt = amt;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 64) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         junk_inputs();
         @(posedge clk); #1;
         n++;
      end
      check("latency", 32'(n), 32'(is_shift(op, amt) ? int'(amt) : 1));
      res = bus.shift_out;
      repeat (stall) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         junk_inputs();
         @(posedge clk); #1;
         check("hold_shift_out", 32'(bus.shift_out), 32'(res));
         check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("in_ready_after_take", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin : driver
      logic [15:0] r;
      logic [15:0] x;
      logic [3:0]  a;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.shift_in  = '0;
      bus.shift_op  = '0;
      bus.shift_amt = '0;

      // Pin the reference model to hand-computed values.
      check("model_lsl1", 32'(ref_shift(16'hF0CF, 3'd1, 4'd1)), 32'hE19E);
      check("model_lsl1_c", 32'(ref_carry(16'hF0CF, 3'd1, 4'd1)), 32'd1);
      check("model_asr4", 32'(ref_shift(16'hF0CF, 3'd3, 4'd4)), 32'hFF0C);
      check("model_rol4", 32'(ref_shift(16'hF0CF, 3'd4, 4'd4)), 32'h0CFF);
      check("model_asr15", 32'(ref_shift(16'h8000, 3'd3, 4'd15)), 32'hFFFF);

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of a long shift.
      bus.shift_in = 16'hA5A5; bus.shift_op = 3'd1; bus.shift_amt = 4'd9; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("midshift_out_valid", 32'(bus.out_valid), 32'd0);
      check("midshift_in_ready", 32'(bus.in_ready), 32'd1);
      check("midshift_shift_out", 32'(bus.shift_out), 32'd0);
      @(negedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      send(16'hF0CF, 3'd1, 4'd9, 0, r); check("after_reset_lsl9", 32'(r), 32'h9E00);

      send(16'hF0CF, 3'd1, 4'd1, 0, r);  check("lsl1", 32'(r), 32'hE19E);
      send(16'hF0CF, 3'd3, 4'd4, 1, r);  check("asr4", 32'(r), 32'hFF0C);
      send(16'hF0CF, 3'd2, 4'd4, 0, r);  check("lsr4", 32'(r), 32'h0F0C);
      send(16'hF0CF, 3'd4, 4'd4, 0, r);  check("rol4", 32'(r), 32'h0CFF);
      send(16'hF0CF, 3'd5, 4'd4, 2, r);  check("ror4", 32'(r), 32'hFF0C);
      send(16'h8000, 3'd3, 4'd15, 0, r); check("asr15", 32'(r), 32'hFFFF);
      send(16'h1234, 3'd1, 4'd0, 0, r);  check("amt0", 32'(r), 32'h1234);
      send(16'h1234, 3'd6, 4'd7, 0, r);  check("op110", 32'(r), 32'h1234);
      send(16'h1234, 3'd7, 4'd3, 0, r);  check("op111", 32'(r), 32'h1234);
      send(16'h0001, 3'd4, 4'd15, 5, r); check("rol15_stall5", 32'(r), 32'h8000);

      for (int i = 0; i < 300; i++) begin
         x = 16'($urandom);
         case ($urandom_range(0, 3))
            0: a = 4'd0;
            1: a = 4'd15;
            default: a = 4'($urandom_range(0, 15));
         endcase
         send(x, 3'($urandom_range(0, 7)), a, int'($urandom_range(0, 3)), r);
      end

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
